uart_tx_channel: RTL and testbench

//   One serial transmit lane fed by one write/data slice of the USB->UART output mux.

---
 rtl/uart_tx_channel.sv | 102 ++++++++++
 tb/tb_uart_tx_channel.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_channel.sv
// uart_tx_channel: one-entry buffered 8N1/8N2 serial transmitter that drops and flags bytes arriving while full
module uart_tx_channel #(
  parameter int DATA_BITS = 8,
  parameter int COUNTER_BITS = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COUNTER_BITS-1:0] divisor,
  input  logic                    write,
  input  logic [DATA_BITS-1:0]    data,
  output logic                    tx,
  output logic                    busy,
  output logic                    overrun
);
  localparam int IW = $clog2(DATA_BITS + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [COUNTER_BITS-1:0] bit_cnt, cnt_n, div_q, div_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n, hold_data;
  logic hold_valid, tx_n, bit_done, load;
  assign bit_done = bit_cnt == div_q;
  assign busy = hold_valid | (state != IDLE);
  always_comb begin
    state_n = state;
    cnt_n = bit_done ? '0 : bit_cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    div_n = div_q;
    tx_n = tx;
    load = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n = 1'b1;
        load = hold_valid;
      end
      START: if (bit_done) begin
        state_n = DATA;
        tx_n = shift[0];
        idx_n = '0;
      end
      DATA: if (bit_done) begin
        if (idx == IW'(DATA_BITS - 1)) begin
          state_n = STOP;
          tx_n = 1'b1;
          idx_n = '0;
        end else begin
          shift_n = shift >> 1;
          tx_n = shift_n[0];
          idx_n = idx + 1'b1;
        end
      end
      default: if (bit_done) begin
        if (idx == IW'(STOP_BITS - 1)) begin
          state_n = IDLE;
          tx_n = 1'b1;
          idx_n = '0;
          load = hold_valid;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
    endcase
    // a reload from STOP skips IDLE entirely, giving back-to-back frames
    if (load) begin
      state_n = START;
      shift_n = hold_data;
      div_n = divisor;
      cnt_n = '0;
      idx_n = '0;
      tx_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      div_q <= '0;
      idx <= '0;
      shift <= '0;
      hold_data <= '0;
      hold_valid <= 1'b0;
      tx <= 1'b1;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= cnt_n;
      div_q <= div_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      overrun <= write & hold_valid & ~load;
      if (write && (!hold_valid || load)) begin
        hold_data <= data;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_tx_channel.sv
// tb_uart_tx_channel: directed checks of framing, buffering, overrun, reset and divisor latching
module tb_uart_tx_channel;
  logic clk, reset, write, write2, tx, busy, overrun, tx2, busy2, overrun2;
  logic [15:0] divisor;
  logic [7:0] data;
  int checks = 0;
  int errors = 0;

  uart_tx_channel u1 (.clk(clk), .reset(reset), .divisor(divisor), .write(write), .data(data),
                      .tx(tx), .busy(busy), .overrun(overrun));
  uart_tx_channel #(.STOP_BITS(2)) u2 (.clk(clk), .reset(reset), .divisor(divisor), .write(write2),
                      .data(data), .tx(tx2), .busy(busy2), .overrun(overrun2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input bit sel);
    chk("idle tx", sel ? tx2 : tx, 1);
    chk("idle busy", sel ? busy2 : busy, 0);
    chk("idle overrun", sel ? overrun2 : overrun, 0);
  endtask

  // write one byte into an idle lane and step to the first cycle of its frame
  task automatic start(input bit sel, input logic [7:0] b);
    data = b;
    if (sel) write2 = 1'b1; else write = 1'b1;
    tick();
    write = 1'b0;
    write2 = 1'b0;
    chk("cap tx", sel ? tx2 : tx, 1);
    chk("cap busy", sel ? busy2 : busy, 1);
    tick();
  endtask

  // check every cycle of one frame; optional writes, expected overrun cycle and divisor change
  task automatic run_frame(input bit sel, input logic [7:0] b, input int div,
                           input int wa, input logic [7:0] wb, input int wa2, input logic [7:0] wb2,
                           input int ovr_at, input int dv_at, input logic [15:0] dv);
    int nbits;
    int c;
    logic e;
    nbits = sel ? 11 : 10;
    c = 0;
    for (int i = 0; i < nbits; i++)
      for (int k = 0; k <= div; k++) begin
        e = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1;
        chk($sformatf("tx byte %0h bit %0d cyc %0d", b, i, k), sel ? tx2 : tx, e);
        chk($sformatf("busy byte %0h cyc %0d", b, c), sel ? busy2 : busy, 1);
        chk($sformatf("overrun byte %0h cyc %0d", b, c), sel ? overrun2 : overrun, c == ovr_at);
        if (c == dv_at) divisor = dv;
        if (sel) write2 = (c == wa) || (c == wa2); else write = (c == wa) || (c == wa2);
        data = (c == wa2) ? wb2 : wb;
        tick();
        c++;
      end
    write = 1'b0;
    write2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    write = 1'b0;
    write2 = 1'b0;
    data = '0;
    divisor = 16'd3;
    #3;
    idle(0);
    idle(1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    idle(0);
    idle(1);
    // single frame
    start(0, 8'hA5);
    run_frame(0, 8'hA5, 3, -1, 0, -1, 0, -1, -1, 0);
    idle(0);
    // second byte written 5 cycles after the first: back-to-back, no overrun
    start(0, 8'h01);
    run_frame(0, 8'h01, 3, 3, 8'hFF, -1, 0, -1, -1, 0);
    run_frame(0, 8'hFF, 3, -1, 0, -1, 0, -1, -1, 0);
    idle(0);
    // write into a full buffer is dropped
    start(0, 8'h33);
    run_frame(0, 8'h33, 3, 0, 8'h11, 1, 8'h22, 2, -1, 0);
    run_frame(0, 8'h11, 3, -1, 0, -1, 0, -1, -1, 0);
    idle(0);
    repeat (5) tick();
    idle(0);
    // write on the reload cycle is accepted
    start(0, 8'h3C);
    run_frame(0, 8'h3C, 3, 0, 8'h5A, 39, 8'hC6, -1, -1, 0);
    run_frame(0, 8'h5A, 3, -1, 0, -1, 0, -1, -1, 0);
    run_frame(0, 8'hC6, 3, -1, 0, -1, 0, -1, -1, 0);
    idle(0);
    // reset during data bit 3
    start(0, 8'h00);
    repeat (17) tick();
    chk("pre-reset tx", tx, 0);
    chk("pre-reset busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async reset tx", tx, 1);
    chk("async reset busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    idle(0);
    start(0, 8'h69);
    run_frame(0, 8'h69, 3, -1, 0, -1, 0, -1, -1, 0);
    idle(0);
    // divisor change mid-frame applies to the next frame only
    start(0, 8'h81);
    run_frame(0, 8'h81, 3, 0, 8'h7E, -1, 0, -1, 10, 16'd7);
    run_frame(0, 8'h7E, 7, -1, 0, -1, 0, -1, -1, 0);
    idle(0);
    // one-cycle bit time
    divisor = 16'd0;
    start(0, 8'h96);
    run_frame(0, 8'h96, 0, -1, 0, -1, 0, -1, -1, 0);
    idle(0);
    // two stop bits
    divisor = 16'd3;
    start(1, 8'hC3);
    run_frame(1, 8'hC3, 3, -1, 0, -1, 0, -1, -1, 0);
    idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
